// File: rtl/lcd_spi_pkg.sv
// lcd_spi_pkg: shared state encoding, DC levels and byte-enable search for lcd_spi_tx.
package lcd_spi_pkg;

    typedef enum logic [2:0] {ST_RST, ST_WAKE, ST_IDLE, ST_SHIFT, ST_GAP} state_t;

    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

    // Highest enabled byte index strictly below idx; bit 2 flags that one exists.
    // Passing idx = bytes-per-word yields the first byte of a word.
    function automatic logic [2:0] next_kept_byte(input logic [3:0] keep, input logic [2:0] idx);
        next_kept_byte = 3'b000;
        for (int i = 0; i < 4; i++)
            if (keep[i] && i < int'(idx))
                next_kept_byte = {1'b1, 2'(i)};
    endfunction

endpackage

// File: rtl/lcd_spi_tick_gen.sv
// lcd_spi_tick_gen: SCK half-period divider emitting rise/fall strobes while enabled.
module lcd_spi_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic CLK,
    input  logic RESET,
    input  logic en,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(CLK_DIV + 1);

    logic [CW-1:0] cnt;
    logic          phase;
    logic          wrap;

    assign wrap = cnt == CW'(CLK_DIV - 1);
    assign rise = en && wrap && !phase;
    assign fall = en && wrap && phase;

    // Free-running half-period counter, parked at phase 0 whenever disabled.
    always_ff @(posedge CLK) begin
        if (RESET || !en) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (wrap) begin
            cnt   <= '0;
            phase <= !phase;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/lcd_spi_tx.sv
// lcd_spi_tx: AXI-Stream to SPI mode-0 serializer for ST7789-class panels; optional LCD_CS via LCD_SPI_TX_CS_EN.
module lcd_spi_tx
    import lcd_spi_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int CLK_DIV     = 2,
    parameter int RST_CYCLES  = 1000,
    parameter int WAKE_CYCLES = 12000000,
    parameter int GAP_CYCLES  = 4
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    BACKLIGHT,
    input  logic [DATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic [DATA_WIDTH/8-1:0] S_AXIS_TKEEP,
    input  logic                    S_AXIS_TUSER,
    input  logic                    S_AXIS_TVALID,
    input  logic                    S_AXIS_TLAST,
    output logic                    S_AXIS_TREADY,
    output logic                    INIT_DONE,
    output logic                    LCD_BLK,
    output logic                    LCD_RST,
    output logic                    LCD_DC,
    output logic                    LCD_SDA,
    output logic                    LCD_SCK
`ifdef LCD_SPI_TX_CS_EN
    ,
    output logic                    LCD_CS
`endif
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int BW = $clog2(DATA_WIDTH);
    localparam int MC = RST_CYCLES > WAKE_CYCLES ? (RST_CYCLES > GAP_CYCLES ? RST_CYCLES : GAP_CYCLES)
                                                 : (WAKE_CYCLES > GAP_CYCLES ? WAKE_CYCLES : GAP_CYCLES);
    localparam int CW = $clog2(MC + 1);

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [BW-1:0]         pos;
    logic [DATA_WIDTH-1:0] data_r;
    logic [NB-1:0]         keep_r;
    logic                  last_r;
    logic                  empty_r;
    logic                  rise;
    logic                  fall;
    logic                  hs;
    logic                  fin;
    logic [2:0]            first_kb;
    logic [2:0]            next_kb;
    logic [BW-1:0]         first_pos;
    logic [BW-1:0]         nxt_pos;

    // pos is a bit index into the whole word; on a byte boundary jump to the next kept byte's MSB.
    assign first_kb  = next_kept_byte(4'(S_AXIS_TKEEP), 3'(NB));
    assign next_kb   = next_kept_byte(4'(keep_r), 3'(pos >> 3));
    assign first_pos = BW'({first_kb[1:0], 3'b111});
    assign nxt_pos   = pos[2:0] == 3'd0 ? BW'({next_kb[1:0], 3'b111}) : pos - 1'b1;
    assign hs        = state == ST_IDLE && S_AXIS_TREADY && S_AXIS_TVALID;
    assign fin       = state == ST_SHIFT && (empty_r || (fall && pos[2:0] == 3'd0 && !next_kb[2]));

    lcd_spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .CLK   (CLK),
        .RESET (RESET),
        .en    (state == ST_SHIFT),
        .rise  (rise),
        .fall  (fall)
    );

    // Panel init sequencing, word handshake and bit shifting with registered pin outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state         <= ST_RST;
            cnt           <= '0;
            pos           <= '0;
            data_r        <= '0;
            keep_r        <= '0;
            last_r        <= 1'b0;
            empty_r       <= 1'b0;
            LCD_RST       <= 1'b0;
            LCD_SCK       <= 1'b0;
            LCD_SDA       <= 1'b0;
            LCD_DC        <= DC_CMD;
            S_AXIS_TREADY <= 1'b0;
            INIT_DONE     <= 1'b0;
        end else begin
            case (state)
                ST_RST:
                    if (cnt == CW'(RST_CYCLES - 1)) begin
                        state   <= ST_WAKE;
                        cnt     <= '0;
                        LCD_RST <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                ST_WAKE:
                    if (cnt == CW'(WAKE_CYCLES - 1)) begin
                        state         <= ST_IDLE;
                        cnt           <= '0;
                        INIT_DONE     <= 1'b1;
                        S_AXIS_TREADY <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                ST_IDLE:
                    if (hs) begin
                        state         <= ST_SHIFT;
                        S_AXIS_TREADY <= 1'b0;
                        data_r        <= S_AXIS_TDATA;
                        keep_r        <= S_AXIS_TKEEP;
                        last_r        <= S_AXIS_TLAST;
                        empty_r       <= !first_kb[2];
                        LCD_DC        <= S_AXIS_TUSER;
                        pos           <= first_pos;
                        if (first_kb[2])
                            LCD_SDA <= S_AXIS_TDATA[first_pos];
                    end
                ST_SHIFT:
                    if (fin) begin
                        state         <= last_r ? ST_GAP : ST_IDLE;
                        S_AXIS_TREADY <= !last_r;
                        LCD_SCK       <= 1'b0;
                        cnt           <= '0;
                    end else if (rise) begin
                        LCD_SCK <= 1'b1;
                    end else if (fall) begin
                        LCD_SCK <= 1'b0;
                        pos     <= nxt_pos;
                        LCD_SDA <= data_r[nxt_pos];
                    end
                ST_GAP:
                    if (cnt == CW'(GAP_CYCLES - 1)) begin
                        state         <= ST_IDLE;
                        cnt           <= '0;
                        S_AXIS_TREADY <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                default: state <= ST_RST;
            endcase
        end
    end

    // Backlight follows its request one clock later, independent of the FSM.
    always_ff @(posedge CLK) LCD_BLK <= RESET ? 1'b0 : BACKLIGHT;

`ifdef LCD_SPI_TX_CS_EN
    // Chip select spans a whole transaction: first handshake until the TLAST word's final bit.
    always_ff @(posedge CLK) LCD_CS <= RESET ? 1'b1 : hs ? 1'b0 : (fin && last_r) ? 1'b1 : LCD_CS;
`endif

endmodule
